truth_table_scanner: RTL and testbench
======================================

// Module: truth_table_scanner
// PURPOSE
//   Sequential stimulus/readback engine for combinational expression blocks.
//   - Walks all 2^N_IN input combinations onto a DUT.
//   - Samples the DUT output for each one and packs the results into a truth-table vector.
//   - Replaces hand-written #1 sweep benches with a synthesizable, on-chip scanner.
//   - Sits between a controller (start/done) and any N_IN-input, 1-output function.
// PARAMETERS
//   N_IN        3   number of DUT inputs; table width is 2**N_IN (range 1..6)
//   SETTLE_CYC  1   cycles stim is held before sampling (range 0..255)
// PORTS
//   clk       in   1          rising-edge clock
//   rst_n     in   1          synchronous, active-low reset
//   start     in   1          scan request, sampled only in IDLE
//   dut_out   in   1          DUT output being read back
//   stim      out  N_IN       DUT input vector; MSB = first operand (x), LSB = last (z)
//   busy      out  1          1 while a scan is in progress
//   done      out  1          1-cycle pulse when the table is complete
//   table_o   out  2**N_IN    bit i = dut_out sampled while stim == i
// BEHAVIOUR
//   Reset (rst_n==0 at clk edge):
//     state=IDLE; stim=0; busy=0; done=0; table_o=0; idx=0; settle cnt=0.
//   States: IDLE -> WAIT -> SAMPLE -> (WAIT | DONE) -> IDLE
//   - IDLE:   start=1 -> idx=0, stim=0, cnt=SETTLE_CYC.
//             Next state is WAIT, or SAMPLE if SETTLE_CYC==0.
//             table_o is cleared on this start edge.
//   - WAIT:   cnt decrements each cycle; when cnt==1 the next state is SAMPLE.
//             Stays in WAIT for exactly SETTLE_CYC cycles.
//   - SAMPLE: table_o[idx] <= dut_out.
//             If idx == 2**N_IN-1 -> DONE.
//             Else idx++, stim=idx+1, cnt reload, next state WAIT (or SAMPLE if SETTLE_CYC==0).
//   - DONE:   done=1 for this single cycle, then IDLE.
//   Outputs and timing:
//     - busy=1 in WAIT and SAMPLE only.
//     - stim is registered and equals idx throughout WAIT and SAMPLE of a vector.
//     - Per-vector cost is SETTLE_CYC+1 cycles.
//     - start seen at edge T0 gives done=1 during cycle T0 + 1 + 2**N_IN*(SETTLE_CYC+1).
//   Boundary conditions:
//     - start while busy or in DONE: ignored; no queueing.
//     - start held high: a new scan begins on the first IDLE cycle after DONE.
//     - table_o holds its last value from DONE until the next accepted start.
//     - idx never wraps: the terminal check happens before increment.
//     - rst_n low mid-scan: immediate return to reset values; partial table discarded.
//     - dut_out is sampled only in SAMPLE; its value in other states is don't-care.
// CONFIGURATION
//   TT_COMPARE_EN defined:
//     - Adds input  expected_i [2**N_IN-1:0].
//     - Adds output mismatch_o [2**N_IN-1:0] = table_o ^ expected_i, registered in DONE.
//     - Adds output fail_o = |mismatch_o.
//     - Both outputs are cleared on reset and on an accepted start.
//   TT_COMPARE_EN undefined:
//     - These ports and their registers do not exist.
//     - Core behaviour is unchanged.
// TESTING
//   1. rst_n=0 two cycles with start=1
//      -> stim=0, busy=0, done=0, table_o=0; no scan starts.
//   2. N_IN=3, SETTLE_CYC=1, DUT s=~(~x&y)&~z, start pulse at T0
//      -> done at T0+17, table_o=8'h51.
//   3. Same DUT, SETTLE_CYC=0
//      -> done at T0+9, table_o=8'h51, stim steps 0..7 on consecutive cycles.
//   4. start pulsed again at T0+5 while busy
//      -> ignored; single done pulse at T0+17; table_o=8'h51.
//   5. rst_n=0 at T0+8 mid-scan, released, new start
//      -> outputs return to reset values; fresh scan completes with 8'h51.
//   6. [TT_COMPARE_EN] expected_i=8'h51 -> fail_o=0.
//      expected_i=8'h53 -> mismatch_o=8'h02, fail_o=1.

Source files
------------

// File: rtl/truth_table_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_scanner
//  Description : Sequential stimulus/readback engine. Walks all 2**N_IN input
//                combinations onto a 1-output combinational block, holds each
//                vector SETTLE_CYC cycles, samples the response and packs the
//                results into a truth-table vector.
//                Optional feature macro: TT_COMPARE_EN (adds expected_i,
//                mismatch_o and fail_o for on-chip comparison).
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_scanner #(
   parameter int N_IN       = 3,
   parameter int SETTLE_CYC = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 dut_out,
   output logic [N_IN-1:0]      stim,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   table_o
`ifdef TT_COMPARE_EN
   ,
   input  logic [2**N_IN-1:0]   expected_i,
   output logic [2**N_IN-1:0]   mismatch_o,
   output logic                 fail_o
`endif
);

   localparam int              TBL_W    = 2**N_IN;
   localparam logic [7:0]      SETTLE_L = 8'(SETTLE_CYC);
   localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            state_q;
   logic [N_IN-1:0]   idx_q;
   logic [7:0]        cnt_q;
   logic              busy_q;
   logic              done_q;
   logic [TBL_W-1:0]  table_q;
`ifdef TT_COMPARE_EN
   logic [TBL_W-1:0]  mismatch_q;
   logic              fail_q;
`endif

   // Scan controller: sequences vectors, settles, samples and flags completion.
   // idx_q doubles as the registered stimulus, so stim always equals the
   // index of the vector currently being settled or sampled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         table_q    <= '0;
`ifdef TT_COMPARE_EN
         mismatch_q <= '0;
         fail_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  idx_q      <= '0;
                  cnt_q      <= SETTLE_L;
                  table_q    <= '0;
                  busy_q     <= 1'b1;
`ifdef TT_COMPARE_EN
                  mismatch_q <= '0;
                  fail_q     <= 1'b0;
`endif
                  state_q    <= (SETTLE_CYC == 0) ? S_SAMPLE : S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  state_q <= S_SAMPLE;
               end
            end
            S_SAMPLE: begin
               table_q[idx_q] <= dut_out;
               // Terminal check precedes the increment so idx never wraps.
               if (idx_q == LAST_IDX) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  idx_q   <= idx_q + N_IN'(1);
                  cnt_q   <= SETTLE_L;
                  state_q <= (SETTLE_CYC == 0) ? S_SAMPLE : S_WAIT;
               end
            end
            S_DONE: begin
`ifdef TT_COMPARE_EN
               mismatch_q <= table_q ^ expected_i;
               fail_q     <= |(table_q ^ expected_i);
`endif
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign stim    = idx_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign table_o = table_q;
`ifdef TT_COMPARE_EN
   assign mismatch_o = mismatch_q;
   assign fail_o     = fail_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_truth_table_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_truth_table_scanner
//  Description : Directed bench for truth_table_scanner. Two instances share
//                the clock and reset: "a" with SETTLE_CYC=1, "b" with
//                SETTLE_CYC=0. Both read back a selectable 3-input function.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_scanner;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       a_start = 1'b0;
   logic       b_start = 1'b0;
   logic       a_dout, b_dout;
   logic [2:0] a_stim, b_stim;
   logic       a_busy, b_busy, a_done, b_done;
   logic [7:0] a_table, b_table;
   int         fsel = 0;
`ifdef TT_COMPARE_EN
   logic [7:0] exp_in = 8'h51;
   logic [7:0] a_mis, b_mis;
   logic       a_fail, b_fail;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Candidate combinational blocks; x = s[2], y = s[1], z = s[0].
   function automatic logic fn(input int sel, input logic [2:0] s);
      logic x, y, z;
      x = s[2]; y = s[1]; z = s[0];
      case (sel)
         0:       fn = ~(~x & y) & ~z;
         1:       fn = x & y & z;
         2:       fn = x ^ y ^ z;
         3:       fn = 1'b1;
         default: fn = ~z;
      endcase
   endfunction

   assign a_dout = fn(fsel, a_stim);
   assign b_dout = fn(fsel, b_stim);

   truth_table_scanner #(.N_IN(3), .SETTLE_CYC(1)) u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .dut_out(a_dout),
      .stim(a_stim), .busy(a_busy), .done(a_done), .table_o(a_table)
`ifdef TT_COMPARE_EN
      , .expected_i(exp_in), .mismatch_o(a_mis), .fail_o(a_fail)
`endif
   );

   truth_table_scanner #(.N_IN(3), .SETTLE_CYC(0)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .dut_out(b_dout),
      .stim(b_stim), .busy(b_busy), .done(b_done), .table_o(b_table)
`ifdef TT_COMPARE_EN
      , .expected_i(exp_in), .mismatch_o(b_mis), .fail_o(b_fail)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One full scan on instance a (slow=1) or b (slow=0), with latency,
   // stimulus sequence, table, pulse width and hold checks.
   task automatic run_scan(input int slow, input logic [7:0] exp_tab,
                           input int exp_lat, input string tag);
      int   lat;
      int   per;
      logic stim_ok;
      per = (slow != 0) ? 2 : 1;
      @(posedge clk); #1;
      if (slow != 0) a_start = 1'b1; else b_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0; b_start = 1'b0;
      lat = 0;
      stim_ok = 1'b1;
      while (((slow != 0) ? a_done : b_done) !== 1'b1 && lat < 100) begin
         if (((slow != 0) ? a_busy : b_busy) !== 1'b1) stim_ok = 1'b0;
         if (((slow != 0) ? a_stim : b_stim) !== 3'(lat / per)) stim_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_stim_seq"}, {31'd0, stim_ok}, 32'd1);
      check({tag, "_table"}, (slow != 0) ? a_table : b_table, {24'd0, exp_tab});
      @(posedge clk); #1;
      check({tag, "_done_busy_after"},
            (slow != 0) ? {a_done, a_busy} : {b_done, b_busy}, 32'd0);
`ifdef TT_COMPARE_EN
      check({tag, "_mismatch"}, (slow != 0) ? a_mis : b_mis, {24'd0, exp_tab ^ exp_in});
      check({tag, "_fail"}, (slow != 0) ? a_fail : b_fail, {31'd0, |(exp_tab ^ exp_in)});
`endif
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_table_hold"}, (slow != 0) ? a_table : b_table, {24'd0, exp_tab});
   endtask

   typedef struct {
      int         slow;
      int         fsel;
      logic [7:0] exp_tab;
      int         exp_lat;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int ndone;
      int dlat;
      int k;

      vecs[0] = '{1, 0, 8'h51, 16};
      vecs[1] = '{0, 0, 8'h51, 8};
      vecs[2] = '{1, 1, 8'h80, 16};
      vecs[3] = '{0, 2, 8'h96, 8};
      vecs[4] = '{1, 2, 8'h96, 16};
      vecs[5] = '{0, 3, 8'hFF, 8};
      vecs[6] = '{1, 4, 8'h55, 16};
      vecs[7] = '{0, 1, 8'h80, 8};

      // Reset held two cycles with start asserted: nothing may start.
      rst_n = 1'b0; a_start = 1'b1; b_start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_a", {a_stim, a_busy, a_done, a_table}, 32'd0);
      check("reset_b", {b_stim, b_busy, b_done, b_table}, 32'd0);
      a_start = 1'b0; b_start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_after_reset", {a_busy, b_busy, a_done, b_done}, 32'd0);

      // Table-driven scans over several functions and both settle settings.
      for (int i = 0; i < 8; i++) begin
         fsel = vecs[i].fsel;
         run_scan(vecs[i].slow, vecs[i].exp_tab, vecs[i].exp_lat, $sformatf("vec%0d", i));
      end

      // Start re-pulsed while busy is ignored: one done at +16, no rescan.
      fsel = 0;
      @(posedge clk); #1; a_start = 1'b1;
      @(posedge clk); #1; a_start = 1'b0;
      ndone = 0; dlat = -1;
      for (k = 1; k <= 30; k++) begin
         if (k == 5) a_start = 1'b1;
         if (k == 6) a_start = 1'b0;
         @(posedge clk); #1;
         if (a_done === 1'b1) begin
            ndone++;
            dlat = k;
         end
      end
      check("busy_start_done_count", ndone, 1);
      check("busy_start_done_lat", dlat, 16);
      check("busy_start_table", a_table, 32'h51);
      check("busy_start_no_rescan", a_busy, 32'd0);

      // Reset asserted mid-scan at +8 discards the partial table.
      fsel = 0;
      @(posedge clk); #1; a_start = 1'b1;
      @(posedge clk); #1; a_start = 1'b0;
      repeat (7) @(posedge clk);
      #1; rst_n = 1'b0;
      @(posedge clk); #1;
      check("midscan_reset", {a_stim, a_busy, a_done, a_table}, 32'd0);
      rst_n = 1'b1;
      run_scan(1, 8'h51, 16, "after_reset");

      // Start held high: one idle cycle after done, then a fresh scan.
      fsel = 2;
      @(posedge clk); #1; a_start = 1'b1;
      k = 0;
      while (a_done !== 1'b1 && k < 100) begin
         @(posedge clk); #1; k++;
      end
      check("held_first_done", a_done, 32'd1);
      check("held_first_table", a_table, 32'h96);
      @(posedge clk); #1;
      check("held_idle_gap", {a_busy, a_done}, 32'd0);
      fsel = 0;
      @(posedge clk); #1;
      check("held_restart_busy", a_busy, 32'd1);
      check("held_restart_cleared", a_table, 32'd0);
`ifdef TT_COMPARE_EN
      check("held_restart_cmp_cleared", {a_mis, a_fail}, 32'd0);
`endif
      a_start = 1'b0;
      k = 0;
      while (a_done !== 1'b1 && k < 100) begin
         @(posedge clk); #1; k++;
      end
      check("held_second_table", a_table, 32'h51);
      repeat (3) @(posedge clk);

`ifdef TT_COMPARE_EN
      fsel = 0;
      exp_in = 8'h51;
      run_scan(1, 8'h51, 16, "cmp_match");
      check("cmp_match_fail", a_fail, 32'd0);
      exp_in = 8'h53;
      run_scan(1, 8'h51, 16, "cmp_diff");
      check("cmp_diff_mismatch", a_mis, 32'h02);
      check("cmp_diff_fail", a_fail, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
